// File: rtl/and8_chk_pkg.sv
// Shared types, defaults and helpers for the AND8 response checker.
// Queue entries pair the expected reduction result with the cycle stamp of acceptance.
package and8_chk_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 8;
    localparam int DEF_TS_W  = 16;
    localparam int DEF_CNT_W = 16;

    typedef struct packed {
        logic                exp;
        logic [DEF_TS_W-1:0] ts;
    } chk_entry_t;

    // Increment that sticks at the all-ones value of a counter 'width' bits wide.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (val >= max_val) ? max_val : val + 32'd1;
    endfunction

endpackage

// File: rtl/chk_fifo.sv
// Synchronous FIFO of checker entries; head is visible combinationally, push/pop in one cycle.
// A push while full is accepted only when a pop in the same cycle frees the slot.
module chk_fifo
    import and8_chk_pkg::*;
#(
    parameter int  DEPTH   = DEF_DEPTH,
    parameter type entry_t = chk_entry_t
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       push_i,
    input  entry_t                     push_dat_i,
    input  logic                       pop_i,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output entry_t                     head_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            do_push, do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i & (~full_o | pop_i);
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy alone decides which slots are meaningful.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
    end

endmodule

// File: rtl/and8_resp_checker.sv
// In-order response checker for AND8 datapaths; results land one cycle after the compare edge.
// Stim_ready drops only when the queue is full; a 0-latency DUT is served by a same-cycle bypass.
module and8_resp_checker
    import and8_chk_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int TS_W  = DEF_TS_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Stim_valid,
    input  logic [WIDTH-1:0] Stim_data,
    output logic             Stim_ready,
    input  logic             Resp_valid,
    input  logic             Resp_data,
    output logic             Err_pulse,
    output logic [CNT_W-1:0] Err_count,
    output logic [CNT_W-1:0] Pass_count,
    output logic [TS_W-1:0]  Max_lat,
    output logic             Unexp_resp,
    output logic             Busy
);

    typedef struct packed {
        logic            exp;
        logic [TS_W-1:0] ts;
    } entry_t;

    logic [TS_W-1:0]        cyc_q;
    entry_t                 push_ent, head;
    logic                   full, empty;
    logic [$clog2(DEPTH):0] occ;

    logic                   accept, push, pop, bypass, unexp_hit;
    logic                   cmp_vld, cmp_exp, mismatch;
    logic [TS_W-1:0]        lat;

    logic                   err_pulse_q, err_pulse_d;
    logic [CNT_W-1:0]       err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0]       pass_cnt_q, pass_cnt_d;
    logic [TS_W-1:0]        max_lat_q, max_lat_d;
    logic                   unexp_q, unexp_d;

    assign Stim_ready = ~full;
    assign Busy       = (occ != '0);
    assign accept     = Stim_valid & Stim_ready;

    // An empty queue means the response can only belong to this cycle's stimulus, if any.
    assign pop        = Resp_valid & ~empty;
    assign bypass     = Resp_valid & empty & accept;
    assign unexp_hit  = Resp_valid & empty & ~accept;
    assign push       = accept & ~bypass;

    assign push_ent.exp = &Stim_data;
    assign push_ent.ts  = cyc_q;

    assign cmp_vld  = pop | bypass;
    assign cmp_exp  = pop ? head.exp : (&Stim_data);
    assign lat      = pop ? (cyc_q - head.ts) : '0;
    assign mismatch = cmp_vld & (Resp_data != cmp_exp);

    chk_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk_i      (Clk),
        .rst_n_i    (Rst_n),
        .push_i     (push),
        .push_dat_i (push_ent),
        .pop_i      (pop),
        .full_o     (full),
        .empty_o    (empty),
        .count_o    (occ),
        .head_o     (head)
    );

    always_comb begin
        err_pulse_d = mismatch;
        err_cnt_d   = err_cnt_q;
        pass_cnt_d  = pass_cnt_q;
        max_lat_d   = max_lat_q;
        unexp_d     = unexp_q | unexp_hit;
        if (cmp_vld) begin
            if (mismatch) err_cnt_d  = CNT_W'(sat_inc(32'(err_cnt_q), CNT_W));
            else          pass_cnt_d = CNT_W'(sat_inc(32'(pass_cnt_q), CNT_W));
            if (lat > max_lat_q) max_lat_d = lat;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cyc_q       <= '0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
            pass_cnt_q  <= '0;
            max_lat_q   <= '0;
            unexp_q     <= 1'b0;
        end else begin
            cyc_q       <= cyc_q + TS_W'(1);
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
            pass_cnt_q  <= pass_cnt_d;
            max_lat_q   <= max_lat_d;
            unexp_q     <= unexp_d;
        end
    end

    assign Err_pulse  = err_pulse_q;
    assign Err_count  = err_cnt_q;
    assign Pass_count = pass_cnt_q;
    assign Max_lat    = max_lat_q;
    assign Unexp_resp = unexp_q;

endmodule

// File: tb/tb_and8_resp_checker.sv
// Directed bench for and8_resp_checker: a vector table plus hand sequences for queue, reset and saturation cases.
module tb_and8_resp_checker;

    logic        Clk;
    logic        Rst_n;
    logic        Stim_valid;
    logic [7:0]  Stim_data;
    logic        Resp_valid;
    logic        Resp_data;

    logic        rdy0, errp0, unexp0, busy0;
    logic [15:0] errc0, passc0, maxl0;
    logic        rdy1, errp1, unexp1, busy1;
    logic [3:0]  errc1, passc1;
    logic [15:0] maxl1;

    int n_chk;
    int n_fail;

    and8_resp_checker #(.WIDTH(8), .DEPTH(8), .TS_W(16), .CNT_W(16)) dut0 (
        .Clk(Clk), .Rst_n(Rst_n), .Stim_valid(Stim_valid), .Stim_data(Stim_data),
        .Stim_ready(rdy0), .Resp_valid(Resp_valid), .Resp_data(Resp_data),
        .Err_pulse(errp0), .Err_count(errc0), .Pass_count(passc0), .Max_lat(maxl0),
        .Unexp_resp(unexp0), .Busy(busy0)
    );

    and8_resp_checker #(.WIDTH(8), .DEPTH(8), .TS_W(16), .CNT_W(4)) dut1 (
        .Clk(Clk), .Rst_n(Rst_n), .Stim_valid(Stim_valid), .Stim_data(Stim_data),
        .Stim_ready(rdy1), .Resp_valid(Resp_valid), .Resp_data(Resp_data),
        .Err_pulse(errp1), .Err_count(errc1), .Pass_count(passc1), .Max_lat(maxl1),
        .Unexp_resp(unexp1), .Busy(busy1)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    typedef struct {
        logic       sv;
        logic [7:0] sd;
        logic       rv;
        logic       rd;
        int         pass;
        int         err;
        logic       errp;
        int         maxl;
        logic       busy;
        logic       rdy;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
        end
    endtask

    task automatic step(input logic sv, input logic [7:0] sd, input logic rv, input logic rd);
        Stim_valid = sv;
        Stim_data  = sd;
        Resp_valid = rv;
        Resp_data  = rd;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        Rst_n      = 1'b0;
        Stim_valid = 1'b0;
        Stim_data  = 8'h00;
        Resp_valid = 1'b0;
        Resp_data  = 1'b0;

        //          sv    sd     rv    rd    pass err errp  maxl busy  rdy
        vecs[0]  = '{1'b1, 8'hFF, 1'b1, 1'b1, 1,   0,  1'b0, 0,   1'b0, 1'b1}; // bypass match
        vecs[1]  = '{1'b1, 8'hFE, 1'b0, 1'b0, 1,   0,  1'b0, 0,   1'b1, 1'b1}; // push exp=0
        vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1,   0,  1'b0, 0,   1'b1, 1'b1};
        vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1,   0,  1'b0, 0,   1'b1, 1'b1};
        vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1,   1,  1'b1, 3,   1'b0, 1'b1}; // mismatch, lat 3
        vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1,   1,  1'b0, 3,   1'b0, 1'b1};
        vecs[6]  = '{1'b1, 8'h0F, 1'b1, 1'b0, 2,   1,  1'b0, 3,   1'b0, 1'b1};
        vecs[7]  = '{1'b1, 8'hFF, 1'b1, 1'b0, 2,   2,  1'b1, 3,   1'b0, 1'b1};
        vecs[8]  = '{1'b1, 8'h00, 1'b1, 1'b1, 2,   3,  1'b1, 3,   1'b0, 1'b1}; // pulse held
        vecs[9]  = '{1'b1, 8'hFF, 1'b0, 1'b0, 2,   3,  1'b0, 3,   1'b1, 1'b1};
        vecs[10] = '{1'b1, 8'h00, 1'b1, 1'b1, 3,   3,  1'b0, 3,   1'b1, 1'b1}; // push+pop
        vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 4,   3,  1'b0, 3,   1'b0, 1'b1};

        // Reset state, before any clock edge
        #3;
        chk("rst pass", 32'(passc0), 0);
        chk("rst err", 32'(errc0), 0);
        chk("rst maxlat", 32'(maxl0), 0);
        chk("rst errpulse", 32'(errp0), 0);
        chk("rst unexp", 32'(unexp0), 0);
        chk("rst busy", 32'(busy0), 0);
        chk("rst ready", 32'(rdy0), 1);
        #9;
        Rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            step(vecs[i].sv, vecs[i].sd, vecs[i].rv, vecs[i].rd);
            chk($sformatf("vec%0d pass", i), 32'(passc0), 32'(vecs[i].pass));
            chk($sformatf("vec%0d err", i), 32'(errc0), 32'(vecs[i].err));
            chk($sformatf("vec%0d errpulse", i), 32'(errp0), 32'(vecs[i].errp));
            chk($sformatf("vec%0d maxlat", i), 32'(maxl0), 32'(vecs[i].maxl));
            chk($sformatf("vec%0d busy", i), 32'(busy0), 32'(vecs[i].busy));
            chk($sformatf("vec%0d ready", i), 32'(rdy0), 32'(vecs[i].rdy));
            chk($sformatf("vec%0d unexp", i), 32'(unexp0), 0);
        end

        // Fill the queue, then offer a ninth stimulus that must be dropped
        for (int k = 1; k <= 8; k++) begin
            step(1'b1, 8'hFF, 1'b0, 1'b0);
            chk($sformatf("fill%0d ready", k), 32'(rdy0), (k < 8) ? 32'd1 : 32'd0);
            chk($sformatf("fill%0d busy", k), 32'(busy0), 1);
        end
        step(1'b1, 8'h00, 1'b0, 1'b0);
        chk("full ninth ready", 32'(rdy0), 0);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        chk("full pop ready", 32'(rdy0), 1);
        chk("full pop pass", 32'(passc0), 5);
        for (int k = 0; k < 7; k++) begin
            step(1'b0, 8'h00, 1'b1, 1'b1);
        end
        chk("drain pass", 32'(passc0), 12);
        chk("drain err", 32'(errc0), 3);
        chk("drain busy", 32'(busy0), 0);
        chk("drain maxlat", 32'(maxl0), 9);

        // Response with nothing outstanding
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("unexp set", 32'(unexp0), 1);
        chk("unexp pass", 32'(passc0), 12);
        chk("unexp err", 32'(errc0), 3);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("unexp sticky", 32'(unexp0), 1);

        // Asynchronous reset with three outstanding entries
        for (int k = 0; k < 3; k++) step(1'b1, 8'hFF, 1'b0, 1'b0);
        chk("pre-rst busy", 32'(busy0), 1);
        Stim_valid = 1'b0;
        Resp_valid = 1'b0;
        #2;
        Rst_n = 1'b0;
        #1;
        chk("arst pass", 32'(passc0), 0);
        chk("arst err", 32'(errc0), 0);
        chk("arst maxlat", 32'(maxl0), 0);
        chk("arst unexp", 32'(unexp0), 0);
        chk("arst busy", 32'(busy0), 0);
        chk("arst ready", 32'(rdy0), 1);
        @(negedge Clk);
        Rst_n = 1'b1;
        step(1'b0, 8'h00, 1'b1, 1'b1);
        chk("post-rst unexp", 32'(unexp0), 1);
        chk("post-rst pass", 32'(passc0), 0);

        // Saturation: 20 bypass mismatches
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 8'hFF, 1'b1, 1'b0);
            if (k == 14) chk("sat at 15", 32'(errc1), 15);
        end
        chk("sat small err", 32'(errc1), 15);
        chk("sat wide err", 32'(errc0), 20);
        chk("sat small pass", 32'(passc1), 0);
        chk("sat errpulse", 32'(errp1), 1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("sat errpulse drop", 32'(errp0), 0);
        chk("sat small hold", 32'(errc1), 15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
